capa_1_scheduler: RTL

CAPA_1_SCHEDULER -- requirements
Module: capa_1_scheduler

---
 rtl/capa_1_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/capa_1_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | capa_1_scheduler                                                         |
// | Sequences binary-pixel x signed-weight accumulation for one dense layer. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module capa_1_scheduler #(
  parameter int NUM_NEURONS = 10,
  parameter int NUM_INPUTS  = 49,
  parameter int ACC_W       = 16,
  parameter int ADDR_W      = 9,
  parameter int IDX_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_INPUTS-1:0]   pixels,
  output logic                    busy,
  output logic                    w_rd_en,
  output logic [ADDR_W-1:0]       w_addr,
  input  logic signed [7:0]       w_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [7:0]       res_data,
  output logic [IDX_W-1:0]        res_idx,
  output logic                    done
);

  localparam int CNT_W = $clog2(NUM_INPUTS);
  localparam logic [CNT_W-1:0] C_LAST_I = CNT_W'(NUM_INPUTS - 1);
  localparam logic [IDX_W-1:0] C_LAST_N = IDX_W'(NUM_NEURONS - 1);
  localparam logic signed [ACC_W-1:0] C_SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] C_SAT_LO = ACC_W'(-128);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DRAIN = 2'd2, OUT = 2'd3} state_t;

  state_t                   state_q, state_d;
  logic [NUM_INPUTS-1:0]    pix_q, pix_d;
  logic [IDX_W-1:0]         neuron_q, neuron_d;
  logic [CNT_W-1:0]         i_q, i_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     rd_q, rd_d;
  logic                     pbit_q, pbit_d;
  logic                     busy_q, busy_d;
  logic                     rd_en_q, rd_en_d;
  logic                     res_valid_q, res_valid_d;
  logic signed [7:0]        res_data_q, res_data_d;
  logic [IDX_W-1:0]         res_idx_q, res_idx_d;
  logic                     done_q, done_d;
  logic signed [ACC_W-1:0]  w_ext;

  assign w_ext = {{(ACC_W-8){w_data[7]}}, w_data};

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    neuron_d   = neuron_q;
    i_d        = i_q;
    addr_d     = addr_q;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;
    done_d     = 1'b0;
    // Read data lands one cycle after the strobe, so the strobe and its pixel bit are delayed to match.
    rd_d       = rd_en_q;
    pbit_d     = pix_q[i_q];
    acc_d      = (rd_q && pbit_q) ? (acc_q + w_ext) : acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pix_d    = pixels;
          neuron_d = '0;
          i_d      = '0;
          addr_d   = '0;
          acc_d    = '0;
          state_d  = ACC;
        end
      end
      ACC: begin
        addr_d = addr_q + ADDR_W'(1);
        if (i_q == C_LAST_I) begin
          i_d     = '0;
          state_d = DRAIN;
        end else begin
          i_d = i_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        state_d   = OUT;
        res_idx_d = neuron_q;
        if (acc_d > C_SAT_HI)      res_data_d = 8'sh7F;
        else if (acc_d < C_SAT_LO) res_data_d = -8'sh80;
        else                       res_data_d = acc_d[7:0];
      end
      OUT: begin
        if (res_ready) begin
          if (neuron_q == C_LAST_N) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            neuron_d = neuron_q + IDX_W'(1);
            i_d      = '0;
            acc_d    = '0;
            state_d  = ACC;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    rd_en_d     = (state_d == ACC);
    res_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      neuron_q    <= '0;
      i_q         <= '0;
      addr_q      <= '0;
      acc_q       <= '0;
      rd_q        <= 1'b0;
      pbit_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      neuron_q    <= neuron_d;
      i_q         <= i_d;
      addr_q      <= addr_d;
      acc_q       <= acc_d;
      rd_q        <= rd_d;
      pbit_q      <= pbit_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign w_rd_en   = rd_en_q;
  assign w_addr    = addr_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;
  assign done      = done_q;

endmodule
`default_nettype wire
